// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage of the five-stage MIPS pipeline. It owns the
//   program counter and issues one instruction-memory request at a time.
//   It feeds instruction / pc_plus_4 to the IF/ID register, and inserts an
//   all-zero word (sll $0,$0,0) whenever no fetched instruction is available.
//
//   Ports
//     clk          : clock, rising edge
//     reset        : asynchronous, active-high
//     stall        : hazard unit holds IF/ID; do not advance
//     redirect     : taken branch/jump from a later stage
//     redirect_pc  : redirect target (bits [1:0] forced to 0)
//     imem_req     : instruction-memory request
//     imem_addr    : word-aligned fetch address
//     imem_ready   : memory completes the request this cycle
//     imem_rdata   : instruction word, valid when imem_req & imem_ready
//     instruction  : to IF/ID Instruction (0 = bubble)
//     pc_plus_4    : to IF/ID PC_plus_4
//     fetch_valid  : instruction carries a real fetched word
//     pc           : current fetch PC (debug)
//
//   Optional build macro IF_FETCH_PERF_EN adds saturating 32-bit counters
//     perf_fetched : instructions consumed downstream
//     perf_bubbles : unstalled cycles without a valid instruction
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_4,
  output logic        fetch_valid,
  output logic [31:0] pc
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] hold_buf;
  logic [31:0] hold_next;
  logic [31:0] pend_pc;
  logic [31:0] pend_next;
  logic [31:0] target;
  logic        req_on;
  logic        done;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign pc_plus_4 = pc + 32'd4;

  // A request is outstanding in FETCH and DRAIN; computed apart from the
  // FSM block so that done does not feed back through it.
  assign req_on = !reset && ((state == FETCH) || (state == DRAIN));
  assign done   = req_on && imem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      hold_buf <= 32'd0;
      pend_pc  <= 32'd0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      hold_buf <= hold_next;
      pend_pc  <= pend_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    hold_next   = hold_buf;
    pend_next   = pend_pc;
    imem_req    = req_on;
    imem_addr   = pc;
    instruction = 32'd0;
    fetch_valid = 1'b0;

    if (!reset) begin
      case (state)
        FETCH: begin
          if (redirect) begin
            // Zero-penalty redirect when the current fetch completes now;
            // otherwise the issued request must be allowed to finish.
            if (done) begin
              pc_next = target;
            end else begin
              pend_next  = target;
              state_next = DRAIN;
            end
          end else if (done) begin
            instruction = imem_rdata;
            fetch_valid = 1'b1;
            if (!stall) begin
              pc_next = pc_plus_4;
            end else begin
              hold_next  = imem_rdata;
              state_next = HOLD;
            end
          end
        end

        HOLD: begin
          if (redirect) begin
            pc_next    = target;
            state_next = FETCH;
          end else begin
            instruction = hold_buf;
            fetch_valid = 1'b1;
            if (!stall) begin
              pc_next    = pc_plus_4;
              state_next = FETCH;
            end
          end
        end

        DRAIN: begin
          // imem_addr stays at the old pc; the latest redirect target wins.
          if (redirect) begin
            pend_next = target;
          end
          if (done) begin
            pc_next    = redirect ? target : pend_pc;
            state_next = FETCH;
          end
        end

        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

`ifdef IF_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else begin
      if (fetch_valid && !stall && !redirect) begin
        perf_fetched <= sat_inc(perf_fetched);
      end
      if (!fetch_valid && !stall) begin
        perf_bubbles <= sat_inc(perf_bubbles);
      end
    end
  end
`endif

endmodule
